// File: rtl/aes_loader_pkg.sv
// Shared constants and FSM state type for the AES byte-serial loader.
// Command bytes and field lengths live here so the loader and its bench agree.
package aes_loader_pkg;

  localparam logic [7:0] CMD_KEY  = 8'h6B;
  localparam logic [7:0] CMD_PT   = 8'h70;
  localparam logic [7:0] CMD_SIZE = 8'h73;

  localparam int unsigned KEY_BYTES = 32;
  localparam int unsigned PT_BYTES  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRxKey,
    StRxSize,
    StRxPt,
    StLoad,
    StWaitHi,
    StWaitLo,
    StTx
  } state_e;

endpackage

// File: rtl/aes_byte_loader_if.sv
// Byte streams (rx/tx) plus the wide aes_core load/result bus, bundled for the loader.
// master = loader side, slave = host bridge / core side.
interface aes_byte_loader_if;

  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         core_load;
  logic [255:0] core_key;
  logic [127:0] core_data;
  logic [1:0]   core_size;
  logic         core_dec;
  logic [127:0] core_result;
  logic         core_busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, core_result, core_busy,
    output rx_ready, tx_data, tx_valid, core_load, core_key, core_data, core_size, core_dec
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, core_result, core_busy,
    input  rx_ready, tx_data, tx_valid, core_load, core_key, core_data, core_size, core_dec
  );

endinterface

// File: rtl/byte_shift_reg.sv
// Byte-wide shift-in shadow register; first byte ends up in the most significant position.
// next_o is the value including the current byte, so the owner can commit it on done_o.
module byte_shift_reg #(
  parameter int unsigned NumBytes = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [7:0]            byte_i,
  output logic [NumBytes*8-1:0] next_o,
  output logic                  done_o
);

  localparam int unsigned Width = NumBytes * 8;
  localparam int unsigned CntW  = $clog2(NumBytes);

  logic [Width-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;

  assign next_o = {shift_q[Width-9:0], byte_i};
  assign done_o = en_i && (cnt_q == CntW'(NumBytes - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      shift_q <= next_o;
      cnt_q   <= done_o ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/aes_byte_loader.sv
// Byte-serial command front-end for aes_core: assembles key/size/plaintext, runs the core,
// and streams the 128-bit result back MSB first. err_o pulses on bad commands or timeout.
module aes_byte_loader
  import aes_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  aes_byte_loader_if.master         bus,
  output logic                      err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [127:0]   data_q, data_d;
  logic [1:0]     size_q, size_d;
  logic [127:0]   result_q, result_d;
  logic [3:0]     tx_cnt_q, tx_cnt_d;
  logic [CntW-1:0] to_cnt_q, to_cnt_d;
  logic           err_q, err_d;

  logic           rx_fire, tx_fire, timed_out;
  logic           key_en, pt_en, key_done, pt_done, shadow_clr;
  logic [255:0]   key_next;
  logic [127:0]   pt_next;
  logic [6:0]     tx_base;

  assign rx_fire   = bus.rx_valid & bus.rx_ready;
  assign tx_fire   = bus.tx_valid & bus.tx_ready;
  assign timed_out = (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  assign key_en     = (state_q == StRxKey) && rx_fire;
  assign pt_en      = (state_q == StRxPt) && rx_fire;
  assign shadow_clr = (state_q == StIdle);

  byte_shift_reg #(.NumBytes(KEY_BYTES)) u_key_shadow (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (shadow_clr),
    .en_i   (key_en),
    .byte_i (bus.rx_data),
    .next_o (key_next),
    .done_o (key_done)
  );

  byte_shift_reg #(.NumBytes(PT_BYTES)) u_pt_shadow (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (shadow_clr),
    .en_i   (pt_en),
    .byte_i (bus.rx_data),
    .next_o (pt_next),
    .done_o (pt_done)
  );

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    data_d   = data_q;
    size_d   = size_q;
    result_d = result_q;
    tx_cnt_d = tx_cnt_q;
    to_cnt_d = to_cnt_q;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          case (bus.rx_data)
            CMD_KEY:  state_d = StRxKey;
            CMD_SIZE: state_d = StRxSize;
            CMD_PT:   state_d = StRxPt;
            default:  err_d = 1'b1;
          endcase
        end
      end
      StRxKey: begin
        if (key_done) begin
          key_d   = key_next;
          state_d = StIdle;
        end
      end
      StRxSize: begin
        if (rx_fire) begin
          if (bus.rx_data <= 8'd2) begin
            size_d = bus.rx_data[1:0];
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      StRxPt: begin
        if (pt_done) begin
          data_d  = pt_next;
          state_d = StLoad;
        end
      end
      StLoad: begin
        to_cnt_d = '0;
        state_d  = StWaitHi;
      end
      StWaitHi: begin
        if (timed_out) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + CntW'(1);
          if (bus.core_busy) state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        // A completing core wins over a timeout landing on the same cycle.
        if (!bus.core_busy) begin
          result_d = bus.core_result;
          tx_cnt_d = '0;
          state_d  = StTx;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + CntW'(1);
        end
      end
      StTx: begin
        if (tx_fire) begin
          if (tx_cnt_q == 4'd15) begin
            state_d = StIdle;
          end else begin
            tx_cnt_d = tx_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      key_q    <= '0;
      data_q   <= '0;
      size_q   <= '0;
      result_q <= '0;
      tx_cnt_q <= '0;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      data_q   <= data_d;
      size_q   <= size_d;
      result_q <= result_d;
      tx_cnt_q <= tx_cnt_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign tx_base = {4'd15 - tx_cnt_q, 3'b000};

  assign bus.rx_ready  = (state_q == StIdle) || (state_q == StRxKey) ||
                         (state_q == StRxSize) || (state_q == StRxPt);
  assign bus.tx_valid  = (state_q == StTx);
  assign bus.tx_data   = (state_q == StTx) ? result_q[tx_base +: 8] : 8'h00;
  assign bus.core_load = (state_q == StLoad);
  assign bus.core_key  = key_q;
  assign bus.core_data = data_q;
  assign bus.core_size = size_q;
  assign bus.core_dec  = 1'b0;
  assign err_o         = err_q;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Directed bench for aes_byte_loader with a simple aes_core stand-in (busy for 10 cycles,
// result = data ^ key[127:0]).
module tb_aes_byte_loader;
  import aes_loader_pkg::*;

  localparam int unsigned TO = 64;

  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R1  = 128'h10003020504070609080b0a0d0c0f0e0;
  localparam logic [127:0] PT2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] R2  = 128'he0f0c0d0a0b080906070405020300010;
  localparam logic [127:0] PT3 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] PT4 = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
  localparam logic [127:0] PT5 = 128'h0123456789abcdeffedcba9876543210;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  aes_byte_loader_if bus ();

  aes_byte_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .err_o (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit core_en = 1'b1;
  int busy_left = 0;
  int n_load = 0;
  int n_errp = 0;
  logic [7:0] txq[$];

  assign bus.core_busy   = (busy_left != 0);
  assign bus.core_result = bus.core_data ^ bus.core_key[127:0];

  always @(posedge clk or posedge rst) begin
    if (rst) busy_left <= 0;
    else if (core_en && bus.core_load) busy_left <= 10;
    else if (busy_left != 0) busy_left <= busy_left - 1;
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.core_load) n_load <= n_load + 1;
      if (err) n_errp <= n_errp + 1;
      if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("rx_ready_wait", {255'd0, bus.rx_ready}, 256'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_field(input logic [255:0] v, input int nb);
    for (int i = 0; i < nb; i++) send_byte(v[8*(nb-1-i) +: 8]);
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (txq.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("tx_count", 256'(txq.size()), 256'(n));
  endtask

  function automatic logic [127:0] q2res();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], (i < txq.size()) ? txq[i] : 8'h00};
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int l0;
    int e0;
    int k;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", {255'd0, bus.rx_ready}, 256'd1);
    chk("rst_tx_valid", {255'd0, bus.tx_valid}, 256'd0);
    chk("rst_tx_data", 256'(bus.tx_data), 256'd0);
    chk("rst_core_load", {255'd0, bus.core_load}, 256'd0);
    chk("rst_core_key", bus.core_key, 256'd0);
    chk("rst_core_data", 256'(bus.core_data), 256'd0);
    chk("rst_core_size", 256'(bus.core_size), 256'd0);
    chk("rst_core_dec", {255'd0, bus.core_dec}, 256'd0);
    chk("rst_err", {255'd0, err}, 256'd0);
    rst = 1'b0;

    // Key load then plaintext run
    send_byte(CMD_KEY);
    send_field(KEY, 32);
    chk("key_loaded", bus.core_key, KEY);
    txq.delete();
    l0 = n_load;
    send_byte(CMD_PT);
    send_field(256'(PT1), 16);
    chk("load_latency", {255'd0, bus.core_load}, 256'd1);
    chk("pt1_data", 256'(bus.core_data), 256'(PT1));
    wait_tx(16);
    chk("result1", 256'(q2res()), 256'(R1));
    chk("load_once", 256'(n_load - l0), 256'd1);
    chk("rx_ready_after_tx", {255'd0, bus.rx_ready}, 256'd1);

    // Backpressure on the third result byte
    txq.delete();
    send_byte(CMD_PT);
    send_field(256'(PT2), 16);
    k = 0;
    while (txq.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    bus.tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", 256'(bus.tx_data), 256'h00c0);
    end
    chk("bp_rx_ready", {255'd0, bus.rx_ready}, 256'd0);
    bus.tx_ready = 1'b1;
    k = 0;
    while (txq.size() < 15 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rx_ready_last_byte", {255'd0, bus.rx_ready}, 256'd0);
    wait_tx(16);
    chk("result2", 256'(q2res()), 256'(R2));

    // Bad command, then a normal run
    e0 = n_errp;
    send_byte(8'h41);
    chk("bad_cmd_err", {255'd0, err}, 256'd1);
    @(posedge clk);
    #1;
    chk("bad_cmd_pulse_end", {255'd0, err}, 256'd0);
    chk("bad_cmd_err_count", 256'(n_errp - e0), 256'd1);
    txq.delete();
    send_byte(CMD_PT);
    send_field(256'(PT1), 16);
    wait_tx(16);
    chk("result_after_bad", 256'(q2res()), 256'(R1));

    // Size command
    e0 = n_errp;
    send_byte(CMD_SIZE);
    send_byte(8'h03);
    chk("size3_err", {255'd0, err}, 256'd1);
    chk("size3_keep", 256'(bus.core_size), 256'd0);
    send_byte(CMD_SIZE);
    send_byte(8'h02);
    chk("size2_no_err", {255'd0, err}, 256'd0);
    chk("size2_set", 256'(bus.core_size), 256'd2);
    chk("size_err_count", 256'(n_errp - e0), 256'd1);

    // Timeout with a core that never goes busy
    core_en = 1'b0;
    txq.delete();
    send_byte(CMD_PT);
    send_field(256'(PT3), 16);
    repeat (64) @(posedge clk);
    #1;
    chk("to_not_yet", {255'd0, err}, 256'd0);
    @(posedge clk);
    #1;
    chk("to_err", {255'd0, err}, 256'd1);
    chk("to_rx_ready", {255'd0, bus.rx_ready}, 256'd1);
    chk("to_tx_valid", {255'd0, bus.tx_valid}, 256'd0);
    chk("to_data_kept", 256'(bus.core_data), 256'(PT3));
    chk("to_no_tx", 256'(txq.size()), 256'd0);
    send_byte(CMD_SIZE);
    send_byte(8'h01);
    chk("after_to_size", 256'(bus.core_size), 256'd1);
    core_en = 1'b1;

    // Reset in the middle of a plaintext field
    send_byte(CMD_PT);
    send_field(256'(PT4[127:72]), 7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rx_ready", {255'd0, bus.rx_ready}, 256'd1);
    chk("mid_rst_key", bus.core_key, 256'd0);
    chk("mid_rst_data", 256'(bus.core_data), 256'd0);
    chk("mid_rst_size", 256'(bus.core_size), 256'd0);
    chk("mid_rst_load", {255'd0, bus.core_load}, 256'd0);
    chk("mid_rst_tx_valid", {255'd0, bus.tx_valid}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    txq.delete();
    l0 = n_load;
    send_byte(CMD_PT);
    send_field(256'(PT5), 16);
    chk("fresh_data", 256'(bus.core_data), 256'(PT5));
    wait_tx(16);
    chk("fresh_result", 256'(q2res()), 256'(PT5));
    chk("fresh_load_once", 256'(n_load - l0), 256'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
